mode_count_ctrl: RTL and testbench
==================================

# mode_count_ctrl

- Parametrised mode-controlled counter for the board-level top.
- A 2-bit `value` selects clear, count-up, count-down or load, each decoded by exactly one arm, with a programmable step.
- Wrap or saturate arithmetic, a registered activity state, and a bit-slice of the count driven to `led`.

## Interface
Parameters:
- `WIDTH`, 32, counter width; must be ≥ 2.
- `STEP_W`, 4, step input width; must be ≤ `WIDTH`.
- `LED_W`, 8, width of the `led` slice.
- `LED_LSB`, 16, lowest count bit shown on `led`; `LED_LSB+LED_W` must be ≤ `WIDTH`.
- `SAT`, 0, arithmetic mode: 0 = modulo 2^WIDTH wrap, 1 = clamp at 0 / all-ones.

Ports:
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  1 = act on `value`; 0 = freeze count.
- `value`  in  2  mode: 00 clear, 01 up, 10 down, 11 load.
- `step`  in  STEP_W  unsigned increment/decrement, zero-extended to `WIDTH`.
- `load_data`  in  WIDTH  value taken in load mode.
- `count`  out  WIDTH  counter register.
- `led`  out  LED_W  `count[LED_LSB+LED_W-1:LED_LSB]`.
- `state`  out  3  FSM state encoding (from the package).
- `tc`  out  1  one-cycle terminal-count pulse.
- `mode_change`  out  1  one-cycle pulse when `state` changes.

## Operation
- Mode decode is a single case on `value` with four distinct arms: no duplicated or shadowed condition, and no default reachable for a known input.
- FSM states: `ST_IDLE`, `ST_UP`, `ST_DOWN`, `ST_LOADED`, `ST_HOLD`.
- When `enable`=1, transitions from any state:
  - 00 → count ← 0, `ST_IDLE`.
  - 01 → count ← count+step, `ST_UP`.
  - 10 → count ← count−step, `ST_DOWN`.
  - 11 → count ← `load_data`, `ST_LOADED`.
- When `enable`=0:
  - count holds.
  - `ST_IDLE` stays `ST_IDLE`.
  - Any other state goes to `ST_HOLD`.
- Arithmetic is `WIDTH`+1 bits; the extra bit is the carry (up) or borrow (down).
  - `SAT`=0: result truncated to `WIDTH`.
  - `SAT`=1: on carry, count ← all-ones; on borrow, count ← 0.
- `tc` is 1 in the cycle after an update that produced a carry or borrow; this applies to both `SAT` values.
  - Exact landing on all-ones or 0 without carry/borrow does not assert `tc`.
- `step`=0 in up/down mode: count unchanged, `tc`=0, state still moves to `ST_UP`/`ST_DOWN`.
- `mode_change` = 1 in the cycle after `state` takes a new value; repeating the same mode gives 0.
- Load ignores `step` and never asserts `tc`.

## Timing
- All outputs are registered. Latency is 1 cycle from the sampling edge of `enable`/`value`/`step`/`load_data` to `count`, `led`, `state`, `tc` and `mode_change`.
- Reset values, applied immediately on `RST`=1 independent of `CLK`:
  - `count`=0, `led`=0.
  - `state`=`ST_IDLE`.
  - `tc`=0, `mode_change`=0.
- Reset mid-count discards any in-flight update. The first rising edge after `RST` falls evaluates inputs normally; `mode_change` is 0 if that edge selects clear.
- `tc` and `mode_change` may assert in the same cycle.
- Back-to-back wraps produce back-to-back `tc` pulses with no dead cycle.

## Structure
- Package `mode_count_pkg`:
  - Mode constants `MODE_CLEAR`/`MODE_UP`/`MODE_DOWN`/`MODE_LOAD` (2-bit).
  - State enum `ST_IDLE`..`ST_HOLD` (3-bit).
- Sub-module `step_addsub`: combinational, parametrised by `WIDTH`/`STEP_W`/`SAT`.
  - Inputs: operand, step, direction.
  - Outputs: next value and overflow flag.
- Top holds the mode decode, FSM, registers and led slice.

## Test plan
- `WIDTH`=8, `SAT`=0:
  - Load 8'hFE, then up with step=3 → count 8'h01, `tc`=1 for exactly one cycle, state `ST_UP`, `mode_change`=1 on the load cycle and on the first up cycle only.
  - Down from 8'h02 with step=5 → 8'hFD, `tc`=1.
- `WIDTH`=8, `SAT`=1:
  - Same up sequence → count 8'hFF, `tc`=1, and the next up cycle keeps 8'hFF with `tc`=1 again.
  - Down from 8'h02 with step=5 → 8'h00.
- `enable`=0 in `ST_UP` at count 8'h10 for 4 cycles → count stays 8'h10, state `ST_HOLD`, single `mode_change` pulse. Re-enable with up → 8'h10+step.
- Default params: load 32'h00AB_0000, hold → `led`=8'hAB. Clear → `led`=0, state `ST_IDLE`.
- Assert `RST` asynchronously between edges during counting → all outputs 0/`ST_IDLE` before the next edge. Release, then up with step=1 → count 1 after one edge.
- Per mode, with `enable`=1, apply all four `value` codes in sequence → each arm is taken exactly once. Coverage shows no unreachable or duplicated decode arm.

Source files
------------

// File: rtl/mode_count_pkg.sv
// Shared mode codes and FSM state encoding for the mode-controlled counter.
package mode_count_pkg;

   localparam logic [1:0] MODE_CLEAR = 2'b00;
   localparam logic [1:0] MODE_UP    = 2'b01;
   localparam logic [1:0] MODE_DOWN  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UP     = 3'd1,
      ST_DOWN   = 3'd2,
      ST_LOADED = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;

endpackage

// File: rtl/step_addsub.sv
// Combinational add/subtract of a zero-extended step, with carry/borrow
// reported as overflow and optional clamping.
module step_addsub #(
   parameter int WIDTH  = 32,
   parameter int STEP_W = 4,
   parameter int SAT    = 0
) (
   input  logic [WIDTH-1:0]  operand,
   input  logic [STEP_W-1:0] step,
   input  logic              down,
   output logic [WIDTH-1:0]  result,
   output logic              overflow
);

   logic [WIDTH:0] ext_op;
   logic [WIDTH:0] ext_step;
   logic [WIDTH:0] raw;

   assign ext_op   = {1'b0, operand};
   assign ext_step = (WIDTH+1)'(step);
   // The extra top bit is the carry on add and the borrow on subtract.
   assign raw      = down ? (ext_op - ext_step) : (ext_op + ext_step);
   assign overflow = raw[WIDTH];

   always_comb begin
      result = raw[WIDTH-1:0];
      if ((SAT != 0) && overflow)
         result = down ? '0 : '1;
   end

endmodule

// File: rtl/mode_count_ctrl.sv
// Mode-controlled counter: clear/up/down/load decode, activity FSM,
// terminal-count and mode-change pulses, and an led slice of the count.
module mode_count_ctrl
   import mode_count_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int STEP_W  = 4,
   parameter int LED_W   = 8,
   parameter int LED_LSB = 16,
   parameter int SAT     = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              enable,
   input  logic [1:0]        value,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  load_data,
   output logic [WIDTH-1:0]  count,
   output logic [LED_W-1:0]  led,
   output logic [2:0]        state,
   output logic              tc,
   output logic              mode_change
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] arith;
   logic             ovf;
   logic             tc_d;

   step_addsub #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W),
      .SAT    (SAT)
   ) u_addsub (
      .operand  (count_q),
      .step     (step),
      .down     (value == MODE_DOWN),
      .result   (arith),
      .overflow (ovf)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      if (enable) begin
         case (value)
            MODE_CLEAR: begin
               count_d = '0;
               state_d = ST_IDLE;
            end
            MODE_UP: begin
               count_d = arith;
               tc_d    = ovf;
               state_d = ST_UP;
            end
            MODE_DOWN: begin
               count_d = arith;
               tc_d    = ovf;
               state_d = ST_DOWN;
            end
            MODE_LOAD: begin
               count_d = load_data;
               state_d = ST_LOADED;
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         state_d = ST_HOLD;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_q     <= '0;
         tc          <= 1'b0;
         mode_change <= 1'b0;
      end else begin
         count_q     <= count_d;
         tc          <= tc_d;
         mode_change <= (state_d != state_q);
      end
   end

   assign count = count_q;
   assign led   = count_q[LED_LSB+LED_W-1:LED_LSB];
   assign state = state_q;

endmodule

// File: tb/tb_mode_count_ctrl.sv
// Randomized and directed checks of three counter configurations against
// an arithmetic reference model of the counting rules.
module tb_mode_count_ctrl;
   import mode_count_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        enable = 1'b0;
   logic [1:0]  value = 2'b00;
   logic [3:0]  step = 4'd0;
   logic [31:0] load_data = 32'd0;

   logic [7:0]  c0, c1;
   logic [3:0]  l0, l1;
   logic [31:0] c2;
   logic [7:0]  l2;
   logic [2:0]  s0, s1, s2;
   logic        tc0, tc1, tc2, mc0, mc1, mc2;

   int checks = 0;
   int failures = 0;

   int     W[3]    = '{8, 8, 32};
   int     SATV[3] = '{0, 1, 0};
   longint m_cnt[3];
   int     m_st[3];
   bit     m_tc[3];
   bit     m_mc[3];

   always #5 CLK = ~CLK;

   mode_count_ctrl #(.WIDTH(8), .STEP_W(4), .LED_W(4), .LED_LSB(2), .SAT(0)) u_wrap8 (
      .CLK(CLK), .RST(RST), .enable(enable), .value(value), .step(step),
      .load_data(load_data[7:0]), .count(c0), .led(l0), .state(s0), .tc(tc0),
      .mode_change(mc0));

   mode_count_ctrl #(.WIDTH(8), .STEP_W(4), .LED_W(4), .LED_LSB(2), .SAT(1)) u_sat8 (
      .CLK(CLK), .RST(RST), .enable(enable), .value(value), .step(step),
      .load_data(load_data[7:0]), .count(c1), .led(l1), .state(s1), .tc(tc1),
      .mode_change(mc1));

   mode_count_ctrl u_dflt (
      .CLK(CLK), .RST(RST), .enable(enable), .value(value), .step(step),
      .load_data(load_data), .count(c2), .led(l2), .state(s2), .tc(tc2),
      .mode_change(mc2));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0; m_st[i] = int'(ST_IDLE); m_tc[i] = 0; m_mc[i] = 0;
      end
   endtask

   // Counting rules in plain integer arithmetic on a 64-bit signed range.
   task automatic model_upd(input int i, input bit en, input logic [1:0] v,
                            input longint stp, input longint ld);
      longint maxv, s;
      int prev;
      maxv = (longint'(1) << W[i]) - 1;
      prev = m_st[i];
      m_tc[i] = 0;
      if (!en) begin
         if (m_st[i] != int'(ST_IDLE)) m_st[i] = int'(ST_HOLD);
      end else if (v == 2'd0) begin
         m_cnt[i] = 0; m_st[i] = int'(ST_IDLE);
      end else if (v == 2'd1) begin
         s = m_cnt[i] + stp;
         if (s > maxv) begin
            m_tc[i] = 1;
            s = SATV[i] ? maxv : s - (maxv + 1);
         end
         m_cnt[i] = s; m_st[i] = int'(ST_UP);
      end else if (v == 2'd2) begin
         s = m_cnt[i] - stp;
         if (s < 0) begin
            m_tc[i] = 1;
            s = SATV[i] ? 0 : s + (maxv + 1);
         end
         m_cnt[i] = s; m_st[i] = int'(ST_DOWN);
      end else begin
         m_cnt[i] = ld & maxv; m_st[i] = int'(ST_LOADED);
      end
      m_mc[i] = (m_st[i] != prev);
   endtask

   task automatic check_all();
      chk("cnt0", c0, m_cnt[0]);  chk("led0", l0, (m_cnt[0] >> 2) & 15);
      chk("st0", s0, m_st[0]);    chk("tc0", tc0, m_tc[0]);  chk("mc0", mc0, m_mc[0]);
      chk("cnt1", c1, m_cnt[1]);  chk("led1", l1, (m_cnt[1] >> 2) & 15);
      chk("st1", s1, m_st[1]);    chk("tc1", tc1, m_tc[1]);  chk("mc1", mc1, m_mc[1]);
      chk("cnt2", c2, m_cnt[2]);  chk("led2", l2, (m_cnt[2] >> 16) & 255);
      chk("st2", s2, m_st[2]);    chk("tc2", tc2, m_tc[2]);  chk("mc2", mc2, m_mc[2]);
   endtask

   task automatic cycle(input bit en, input logic [1:0] v, input logic [3:0] stp,
                        input logic [31:0] ld);
      enable = en; value = v; step = stp; load_data = ld;
      @(posedge CLK);
      for (int i = 0; i < 3; i++) model_upd(i, en, v, longint'(stp), longint'(ld));
      @(negedge CLK);
      check_all();
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge CLK);
      check_all();
      RST = 1'b0;

      // First edge after reset selecting clear: no mode_change.
      cycle(1, 2'd0, 4'd0, 32'd0);
      chk("rst_clear_mc", mc0, 1'b0);

      // Wrap/saturate on up.
      cycle(1, 2'd3, 4'd0, 32'h0000_00FE);
      chk("load_mc", mc0, 1'b1);
      cycle(1, 2'd3, 4'd0, 32'h0000_00FE);
      cycle(1, 2'd1, 4'd3, 32'd0);
      chk("up_wrap_cnt", c0, 8'h01);
      chk("up_wrap_tc", tc0, 1'b1);
      chk("up_sat_cnt", c1, 8'hFF);
      chk("up_first_mc", mc0, 1'b1);
      chk("up_state", s0, 3'(ST_UP));
      cycle(1, 2'd1, 4'd3, 32'd0);
      chk("up_tc_once", tc0, 1'b0);
      chk("up_mc_once", mc0, 1'b0);
      chk("sat_again_cnt", c1, 8'hFF);
      chk("sat_again_tc", tc1, 1'b1);

      // Borrow on down.
      cycle(1, 2'd3, 4'd0, 32'h0000_0002);
      cycle(1, 2'd2, 4'd5, 32'd0);
      chk("dn_wrap_cnt", c0, 8'hFD);
      chk("dn_wrap_tc", tc0, 1'b1);
      chk("dn_sat_cnt", c1, 8'h00);

      // Exact landing on all-ones without carry.
      cycle(1, 2'd3, 4'd0, 32'h0000_00FC);
      cycle(1, 2'd1, 4'd3, 32'd0);
      chk("exact_ff_tc", tc0, 1'b0);

      // Hold while disabled, then resume.
      cycle(1, 2'd3, 4'd0, 32'h0000_0010);
      cycle(1, 2'd1, 4'd0, 32'd0);
      for (int k = 0; k < 4; k++) cycle(0, 2'd1, 4'd2, 32'd0);
      chk("hold_cnt", c0, 8'h10);
      chk("hold_state", s0, 3'(ST_HOLD));
      cycle(1, 2'd1, 4'd2, 32'd0);
      chk("resume_cnt", c0, 8'h12);

      // led slice on the default configuration.
      cycle(1, 2'd3, 4'd0, 32'h00AB_0000);
      cycle(0, 2'd0, 4'd0, 32'd0);
      chk("led_ab", l2, 8'hAB);
      cycle(1, 2'd0, 4'd0, 32'd0);
      chk("led_clr", l2, 8'h00);
      chk("clr_state", s2, 3'(ST_IDLE));

      // Every decode arm in sequence.
      for (int v = 0; v < 4; v++) cycle(1, 2'(v), 4'd7, 32'h1234_5678);
      for (int v = 3; v >= 0; v--) cycle(1, 2'(v), 4'd9, 32'h8000_00FA);

      // Asynchronous reset between edges.
      cycle(1, 2'd3, 4'd0, 32'h0000_0040);
      enable = 1'b1; value = 2'd1; step = 4'd1;
      @(posedge CLK);
      #2 RST = 1'b1;
      #1 model_reset();
      check_all();
      @(negedge CLK);
      RST = 1'b0;
      cycle(1, 2'd1, 4'd1, 32'd0);
      chk("post_rst_cnt", c2, 32'd1);

      // Randomized traffic, biased so wraps and clamps occur often.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] ld;
         case ($urandom_range(3))
            0: ld = $urandom;
            1: ld = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            2: ld = 32'($urandom_range(15));
            default: ld = 32'h0000_00F0 | 32'($urandom_range(15));
         endcase
         cycle($urandom_range(99) < 85, 2'($urandom_range(3)), 4'($urandom_range(15)), ld);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
